// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, synchronizer depth and
// START/STOP condition helpers used by both target and controller blocks.
package i2c_pkg;

    localparam int I2C_SYNC_STAGES = 2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } i2cState_t;

    // START: SDA falls while SCL is steadily high.
    function automatic logic isStart(input logic sclNow, input logic sclPrev,
                                     input logic sdaNow, input logic sdaPrev);
        return sclNow & sclPrev & ~sdaNow & sdaPrev;
    endfunction

    // STOP: SDA rises while SCL is steadily high.
    function automatic logic isStop(input logic sclNow, input logic sclPrev,
                                    input logic sdaNow, input logic sdaPrev);
        return sclNow & sclPrev & sdaNow & ~sdaPrev;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings raw SCL/SDA pins into the Clk domain and flags SCL edges plus
// START/STOP conditions. A synchronizer chain is followed by one extra delay
// stage so that "now" and "previous" samples are both metastability-free.
module i2c_bus_sync
    import i2c_pkg::*;
(
    input  logic Clk,
    input  logic ResetN,
    input  logic SclIn,
    input  logic SdaIn,
    output logic SclRise,
    output logic SclFall,
    output logic Start,
    output logic Stop,
    output logic SdaS
);

    logic [I2C_SYNC_STAGES-1:0] sclPipe;
    logic [I2C_SYNC_STAGES-1:0] sdaPipe;
    logic sclDly;
    logic sdaDly;
    logic sclS;

    // Synchronizer chains and edge-detect delay stage; idle bus reads as high.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            sclPipe <= '1;
            sdaPipe <= '1;
            sclDly  <= 1'b1;
            sdaDly  <= 1'b1;
        end else begin
            sclPipe <= {sclPipe[I2C_SYNC_STAGES-2:0], SclIn};
            sdaPipe <= {sdaPipe[I2C_SYNC_STAGES-2:0], SdaIn};
            sclDly  <= sclPipe[I2C_SYNC_STAGES-1];
            sdaDly  <= sdaPipe[I2C_SYNC_STAGES-1];
        end
    end

    assign sclS = sclPipe[I2C_SYNC_STAGES-1];
    assign SdaS = sdaPipe[I2C_SYNC_STAGES-1];

    // Edge and bus-condition decode from current and delayed samples.
    always_comb begin
        SclRise = sclS & ~sclDly;
        SclFall = ~sclS & sclDly;
        Start   = isStart(sclS, sclDly, SdaS, sdaDly);
        Stop    = isStop(sclS, sclDly, SdaS, sdaDly);
    end

endmodule

// File: rtl/i2c_target.sv
// I2C target register port. Decodes address, register pointer and data bytes
// from the bus and presents writes as a one-cycle strobe; reads fetch fabric
// data from the current pointer. The pointer auto-increments and survives
// across transactions so a pointer write can be followed by a repeated-START
// read.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR = 7'h2A,
    parameter int NREG = 16,
    localparam int PW = $clog2(NREG)
)(
    input  logic          Clk,
    input  logic          ResetN,
    input  logic          SclIn,
    input  logic          SdaIn,
    output logic          SdaOut,
    output logic          WrStb,
    output logic [PW-1:0] WrAddr,
    output logic [7:0]    WrData,
    output logic [PW-1:0] RdAddr,
    input  logic [7:0]    RdData,
    output logic          Busy
);

    logic sclRise;
    logic sclFall;
    logic start;
    logic stop;
    logic sdaS;

    i2c_bus_sync uSync (
        .Clk     (Clk),
        .ResetN  (ResetN),
        .SclIn   (SclIn),
        .SdaIn   (SdaIn),
        .SclRise (sclRise),
        .SclFall (sclFall),
        .Start   (start),
        .Stop    (stop),
        .SdaS    (sdaS)
    );

    i2cState_t     state, stateNext;
    logic [3:0]    bitCnt, bitCntNext;
    logic [7:0]    shifter, shifterNext;
    logic [PW-1:0] pointer, pointerNext;
    logic          sdaOutQ, sdaOutNext;
    logic          wrStbQ, wrStbNext;
    logic [PW-1:0] wrAddrQ, wrAddrNext;
    logic [7:0]    wrDataQ, wrDataNext;
    logic [7:0]    rxByte;

    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        return (p == PW'(NREG - 1)) ? '0 : p + PW'(1);
    endfunction

    // State and datapath registers.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state   <= ST_IDLE;
            bitCnt  <= '0;
            shifter <= '0;
            pointer <= '0;
            sdaOutQ <= 1'b1;
            wrStbQ  <= 1'b0;
            wrAddrQ <= '0;
            wrDataQ <= '0;
        end else begin
            state   <= stateNext;
            bitCnt  <= bitCntNext;
            shifter <= shifterNext;
            pointer <= pointerNext;
            sdaOutQ <= sdaOutNext;
            wrStbQ  <= wrStbNext;
            wrAddrQ <= wrAddrNext;
            wrDataQ <= wrDataNext;
        end
    end

    // Bus protocol: bits are sampled on SCL rise; SDA is only changed on SCL
    // fall. bitCnt reaching 8 in a receive state means the byte is complete
    // and the next SCL fall starts the ACK slot.
    always_comb begin
        stateNext   = state;
        bitCntNext  = bitCnt;
        shifterNext = shifter;
        pointerNext = pointer;
        sdaOutNext  = sdaOutQ;
        wrStbNext   = 1'b0;
        wrAddrNext  = wrAddrQ;
        wrDataNext  = wrDataQ;
        rxByte      = {shifter[6:0], sdaS};

        if (start) begin
            stateNext   = ST_ADDR;
            bitCntNext  = '0;
            shifterNext = '0;
            sdaOutNext  = 1'b1;
        end else if (stop) begin
            stateNext  = ST_IDLE;
            sdaOutNext = 1'b1;
        end else if (sclRise) begin
            case (state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (bitCnt != 4'd8) begin
                        shifterNext = rxByte;
                        bitCntNext  = bitCnt + 4'd1;
                        if (bitCnt == 4'd7) begin
                            case (state)
                                ST_ADDR: begin
                                    if (rxByte[7:1] != ADDR) begin
                                        stateNext = ST_IDLE;
                                    end
                                end
                                ST_PTR: begin
                                    pointerNext = rxByte[PW-1:0];
                                end
                                default: begin
                                    wrStbNext  = 1'b1;
                                    wrAddrNext = pointer;
                                    wrDataNext = rxByte;
                                end
                            endcase
                        end
                    end
                end
                ST_RDATA: begin
                    if (bitCnt != 4'd8) begin
                        bitCntNext = bitCnt + 4'd1;
                    end
                end
                ST_RDATA_ACK: begin
                    if (sdaS) begin
                        stateNext = ST_IDLE;
                    end else begin
                        pointerNext = ptrInc(pointer);
                    end
                end
                default: begin
                end
            endcase
        end else if (sclFall) begin
            case (state)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (bitCnt == 4'd8) begin
                        sdaOutNext = 1'b0;
                        case (state)
                            ST_ADDR: stateNext = ST_ADDR_ACK;
                            ST_PTR:  stateNext = ST_PTR_ACK;
                            default: stateNext = ST_WDATA_ACK;
                        endcase
                    end
                end
                ST_ADDR_ACK: begin
                    bitCntNext = '0;
                    if (shifter[0]) begin
                        stateNext   = ST_RDATA;
                        sdaOutNext  = RdData[7];
                        shifterNext = {RdData[6:0], 1'b1};
                    end else begin
                        stateNext   = ST_PTR;
                        sdaOutNext  = 1'b1;
                        shifterNext = '0;
                    end
                end
                ST_PTR_ACK: begin
                    stateNext   = ST_WDATA;
                    bitCntNext  = '0;
                    shifterNext = '0;
                    sdaOutNext  = 1'b1;
                end
                ST_WDATA_ACK: begin
                    stateNext   = ST_WDATA;
                    bitCntNext  = '0;
                    shifterNext = '0;
                    sdaOutNext  = 1'b1;
                    pointerNext = ptrInc(pointer);
                end
                ST_RDATA: begin
                    if (bitCnt == 4'd8) begin
                        stateNext  = ST_RDATA_ACK;
                        sdaOutNext = 1'b1;
                    end else if (bitCnt != 4'd0) begin
                        sdaOutNext  = shifter[7];
                        shifterNext = {shifter[6:0], 1'b1};
                    end
                end
                ST_RDATA_ACK: begin
                    // Only reached after an ACK; a NACK already left for IDLE.
                    stateNext   = ST_RDATA;
                    bitCntNext  = '0;
                    sdaOutNext  = RdData[7];
                    shifterNext = {RdData[6:0], 1'b1};
                end
                default: begin
                end
            endcase
        end
    end

    assign SdaOut = sdaOutQ;
    assign WrStb  = wrStbQ;
    assign WrAddr = wrAddrQ;
    assign WrData = wrDataQ;
    assign RdAddr = pointer;
    assign Busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_i2c_target.sv
module tb_i2c_target;

    logic       Clk = 1'b0;
    logic       ResetN = 1'b0;
    logic       scl = 1'b1;
    logic       sdaDrv = 1'b1;
    logic       sdaLine;
    logic       SdaOut;
    logic       WrStb;
    logic [3:0] WrAddr;
    logic [7:0] WrData;
    logic [3:0] RdAddr;
    logic [7:0] RdData;
    logic       Busy;

    int total = 0;
    int bad = 0;
    int sclHighChanges = 0;
    logic sdaOutPrev = 1'b1;
    logic [15:0] stbQ[$];

    always #5 Clk = ~Clk;

    assign sdaLine = sdaDrv & SdaOut;
    assign RdData  = 8'h40 + {4'h0, RdAddr};

    i2c_target #(.ADDR(7'h2A), .NREG(16)) dut (
        .Clk    (Clk),
        .ResetN (ResetN),
        .SclIn  (scl),
        .SdaIn  (sdaLine),
        .SdaOut (SdaOut),
        .WrStb  (WrStb),
        .WrAddr (WrAddr),
        .WrData (WrData),
        .RdAddr (RdAddr),
        .RdData (RdData),
        .Busy   (Busy)
    );

    always @(negedge Clk) begin
        if (WrStb) stbQ.push_back({4'h0, WrAddr, WrData});
        if (SdaOut !== sdaOutPrev && scl === 1'b1) sclHighChanges++;
        sdaOutPrev = SdaOut;
    end

    task automatic qtr();
        repeat (10) @(negedge Clk);
    endtask

    task automatic busStart();
        sdaDrv = 1'b1; qtr();
        scl = 1'b1;    qtr();
        sdaDrv = 1'b0; qtr();
        scl = 1'b0;    qtr();
    endtask

    task automatic busStop();
        sdaDrv = 1'b0; qtr();
        scl = 1'b1;    qtr();
        sdaDrv = 1'b1; qtr();
        repeat (8) @(negedge Clk);
    endtask

    task automatic writeBit(input logic b);
        sdaDrv = b; qtr();
        scl = 1'b1; qtr(); qtr();
        scl = 1'b0; qtr();
    endtask

    task automatic readBit(output logic b);
        sdaDrv = 1'b1; qtr();
        scl = 1'b1; qtr();
        b = sdaLine; qtr();
        scl = 1'b0; qtr();
    endtask

    task automatic writeByte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) writeBit(d[i]);
        readBit(ack);
    endtask

    task automatic readByte(output logic [7:0] d, input logic ackBit);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            readBit(b);
            d[i] = b;
        end
        writeBit(ackBit);
    endtask

    task automatic test_reset();
        total++; if (SdaOut !== 1'b1) begin bad++; $display("FAIL reset_sda got=%b exp=1", SdaOut); end
        total++; if (WrStb !== 1'b0) begin bad++; $display("FAIL reset_wrstb got=%b exp=0", WrStb); end
        total++; if (WrAddr !== 4'h0 || WrData !== 8'h00) begin bad++; $display("FAIL reset_wr got=%h/%h exp=0/00", WrAddr, WrData); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", Busy); end
        total++; if (RdAddr !== 4'h0) begin bad++; $display("FAIL reset_ptr got=%h exp=0", RdAddr); end
    endtask

    task automatic test_write();
        logic a0, a1, a2, a3;
        stbQ.delete();
        busStart();
        writeByte(8'h54, a0);
        total++; if (Busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b exp=1", Busy); end
        writeByte(8'h03, a1);
        writeByte(8'hA5, a2);
        writeByte(8'h5A, a3);
        total++; if ({a0, a1, a2, a3} !== 4'b0000) begin bad++; $display("FAIL wr_acks got=%b exp=0000", {a0, a1, a2, a3}); end
        busStop();
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL wr_busy_stop got=%b exp=0", Busy); end
        total++;
        if (stbQ.size() != 2) begin
            bad++; $display("FAIL wr_stb_count got=%0d exp=2", stbQ.size());
        end else if (stbQ[0] !== 16'h03A5 || stbQ[1] !== 16'h045A) begin
            bad++; $display("FAIL wr_stb_data got=%h,%h exp=03a5,045a", stbQ[0], stbQ[1]);
        end
        total++; if (WrAddr !== 4'h4 || WrData !== 8'h5A) begin bad++; $display("FAIL wr_hold got=%h/%h exp=4/5a", WrAddr, WrData); end
        total++; if (RdAddr !== 4'h5) begin bad++; $display("FAIL wr_ptr got=%h exp=5", RdAddr); end
    endtask

    task automatic test_bad_addr();
        logic a0, a1;
        stbQ.delete();
        busStart();
        writeByte(8'h56, a0);
        total++; if (a0 !== 1'b1) begin bad++; $display("FAIL bad_addr_ack got=%b exp=1", a0); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL bad_addr_busy got=%b exp=0", Busy); end
        writeByte(8'h00, a1);
        total++; if (a1 !== 1'b1) begin bad++; $display("FAIL bad_addr_ignore got=%b exp=1", a1); end
        busStop();
        total++; if (stbQ.size() != 0) begin bad++; $display("FAIL bad_addr_stb got=%0d exp=0", stbQ.size()); end
        total++; if (RdAddr !== 4'h5) begin bad++; $display("FAIL bad_addr_ptr got=%h exp=5", RdAddr); end
    endtask

    task automatic test_wrap();
        logic a;
        stbQ.delete();
        busStart();
        writeByte(8'h54, a);
        writeByte(8'h0F, a);
        writeByte(8'h11, a);
        writeByte(8'h22, a);
        busStop();
        total++;
        if (stbQ.size() != 2) begin
            bad++; $display("FAIL wrap_count got=%0d exp=2", stbQ.size());
        end else if (stbQ[0] !== 16'h0F11 || stbQ[1] !== 16'h0022) begin
            bad++; $display("FAIL wrap_data got=%h,%h exp=0f11,0022", stbQ[0], stbQ[1]);
        end
        total++; if (RdAddr !== 4'h1) begin bad++; $display("FAIL wrap_ptr got=%h exp=1", RdAddr); end
    endtask

    task automatic test_read();
        logic a0, a1, a2;
        logic [7:0] d0, d1;
        stbQ.delete();
        busStart();
        writeByte(8'h54, a0);
        writeByte(8'h05, a1);
        busStart();
        writeByte(8'h55, a2);
        total++; if ({a0, a1, a2} !== 3'b000) begin bad++; $display("FAIL rd_acks got=%b exp=000", {a0, a1, a2}); end
        readByte(d0, 1'b0);
        total++; if (d0 !== 8'h45) begin bad++; $display("FAIL rd_byte0 got=%h exp=45", d0); end
        readByte(d1, 1'b1);
        total++; if (d1 !== 8'h46) begin bad++; $display("FAIL rd_byte1 got=%h exp=46", d1); end
        total++; if (SdaOut !== 1'b1 || Busy !== 1'b0) begin bad++; $display("FAIL rd_nack_release got=%b/%b exp=1/0", SdaOut, Busy); end
        busStop();
        total++; if (RdAddr !== 4'h6) begin bad++; $display("FAIL rd_ptr got=%h exp=6", RdAddr); end
        total++; if (stbQ.size() != 0) begin bad++; $display("FAIL rd_stb got=%0d exp=0", stbQ.size()); end
    endtask

    task automatic test_stop_partial();
        logic a;
        stbQ.delete();
        busStart();
        writeByte(8'h54, a);
        writeByte(8'h09, a);
        writeBit(1'b1); writeBit(1'b0); writeBit(1'b1); writeBit(1'b1);
        busStop();
        total++; if (stbQ.size() != 0) begin bad++; $display("FAIL partial_stb got=%0d exp=0", stbQ.size()); end
        total++; if (Busy !== 1'b0) begin bad++; $display("FAIL partial_busy got=%b exp=0", Busy); end
        total++; if (RdAddr !== 4'h9) begin bad++; $display("FAIL partial_ptr got=%h exp=9", RdAddr); end
    endtask

    task automatic test_back_to_back();
        logic a;
        logic [7:0] d;
        stbQ.delete();
        busStart();
        writeByte(8'h54, a);
        writeByte(8'h08, a);
        writeBit(1'b1); writeBit(1'b1); writeBit(1'b0); writeBit(1'b1);
        busStart();
        writeByte(8'h55, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL b2b_ack got=%b exp=0", a); end
        readByte(d, 1'b1);
        total++; if (d !== 8'h48) begin bad++; $display("FAIL b2b_read got=%h exp=48", d); end
        busStop();
        total++; if (stbQ.size() != 0) begin bad++; $display("FAIL b2b_stb got=%0d exp=0", stbQ.size()); end
    endtask

    task automatic test_reset_mid();
        logic a;
        stbQ.delete();
        busStart();
        writeByte(8'h55, a);
        total++; if (SdaOut !== 1'b0) begin bad++; $display("FAIL rstmid_drive got=%b exp=0", SdaOut); end
        @(negedge Clk); ResetN = 1'b0;
        @(negedge Clk); ResetN = 1'b1;
        total++; if (SdaOut !== 1'b1) begin bad++; $display("FAIL rstmid_sda got=%b exp=1", SdaOut); end
        total++; if (Busy !== 1'b0 || RdAddr !== 4'h0) begin bad++; $display("FAIL rstmid_state got=%b/%h exp=0/0", Busy, RdAddr); end
        writeBit(1'b1); writeBit(1'b0); writeBit(1'b1);
        busStop();
        busStart();
        writeByte(8'h54, a);
        writeByte(8'h02, a);
        writeByte(8'h77, a);
        total++; if (a !== 1'b0) begin bad++; $display("FAIL rstmid_ack got=%b exp=0", a); end
        busStop();
        total++;
        if (stbQ.size() != 1) begin
            bad++; $display("FAIL rstmid_count got=%0d exp=1", stbQ.size());
        end else if (stbQ[0] !== 16'h0277) begin
            bad++; $display("FAIL rstmid_data got=%h exp=0277", stbQ[0]);
        end
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        ResetN = 1'b1;
        repeat (3) @(negedge Clk);
        test_reset();
        test_write();
        test_bad_addr();
        test_wrap();
        test_read();
        test_stop_partial();
        test_back_to_back();
        test_reset_mid();
        total++; if (sclHighChanges != 0) begin bad++; $display("FAIL sda_scl_high got=%0d exp=0", sclHighChanges); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
